// File: rtl/seq_detect_gen.sv
// seq_detect_gen
//   Serial pattern detector for the lab board. A debounced step button shifts
//   the synchronised data switch into a PAT_LEN-bit history, which is compared
//   against two fixed patterns. Supports overlapping or non-overlapping
//   detection, per-pattern enables and a saturating hit counter. The debounce
//   sample rate comes from a built-in clock-enable divider, so the whole block
//   runs on the single MHz clock.
//
// Ports
//   MHz      in   1      system clock
//   Reset    in   1      synchronous reset, active-low
//   PS3      in   1      raw step push-button (asynchronous, bouncy)
//   W        in   1      raw serial data switch (asynchronous)
//   pat_en   in   2      [0] enables PAT_A, [1] enables PAT_B
//   clr_cnt  in   1      synchronous clear of count (wins over an increment)
//   Z        out  1      match flag, held until the next step
//   hit      out  2      per-pattern match flags {B,A}, held until the next step
//   count    out  CNT_W  saturating count of detection events
//   full     out  1      history holds PAT_LEN valid bits
//   led      out  1      constant 1, power indicator

module seq_detect_gen #(
    parameter int                 DIV     = 10000,
    parameter int                 DB_LEN  = 11,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PAT_A   = 4'b1001,
    parameter logic [PAT_LEN-1:0] PAT_B   = 4'b1111,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             MHz,
    input  logic             Reset,
    input  logic             PS3,
    input  logic             W,
    input  logic [1:0]       pat_en,
    input  logic             clr_cnt,
    output logic             Z,
    output logic [1:0]       hit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             led
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous board inputs
    // ------------------------------------------------------------------
    logic ps3_s1, ps3_s2;
    logic w_s1, w_s2;

    always_ff @(posedge MHz) begin
        if (!Reset) begin
            ps3_s1 <= 1'b0;
            ps3_s2 <= 1'b0;
            w_s1   <= 1'b0;
            w_s2   <= 1'b0;
        end else begin
            ps3_s1 <= PS3;
            ps3_s2 <= ps3_s1;
            w_s1   <= W;
            w_s2   <= w_s1;
        end
    end

    // ------------------------------------------------------------------
    // Clock-enable divider: one tick every DIV cycles
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge MHz) begin
        if (!Reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hysteresis debouncer. db_level only moves when every stored sample
    // agrees, so a bouncing button never reaches a new level until it has
    // been stable for DB_LEN consecutive ticks.
    // ------------------------------------------------------------------
    logic [DB_LEN-1:0] db_sr;
    logic              db_level;
    logic              db_level_d;
    logic              step;

    always_ff @(posedge MHz) begin
        if (!Reset) begin
            db_sr      <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            if (tick) begin
                db_sr <= {db_sr[DB_LEN-2:0], ps3_s2};
            end
            if (&db_sr) begin
                db_level <= 1'b1;
            end else if (~|db_sr) begin
                db_level <= 1'b0;
            end
            db_level_d <= db_level;
        end
    end

    // High for exactly one cycle, the cycle after db_level rises.
    assign step = db_level & ~db_level_d;

    // ------------------------------------------------------------------
    // Detector. Matches are judged on the history as it will be after this
    // step, so hit/Z update on the same edge as the shift.
    // ------------------------------------------------------------------
    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_inc;
    logic               full_next;
    logic               m_a;
    logic               m_b;
    logic               match;

    always_comb begin
        hist_next = {hist[PAT_LEN-2:0], w_s2};
        fill_inc  = (fill == FILL_MAX) ? fill : fill + 1'b1;
        full_next = (fill_inc == FILL_MAX);
        m_a       = pat_en[0] & full_next & (hist_next == PAT_A);
        m_b       = pat_en[1] & full_next & (hist_next == PAT_B);
        match     = m_a | m_b;
    end

    always_ff @(posedge MHz) begin
        if (!Reset) begin
            hist <= '0;
            fill <= '0;
            hit  <= 2'b00;
            Z    <= 1'b0;
        end else if (step) begin
            hist <= hist_next;
            // Non-overlap mode: the matched bits stay in hist but are marked
            // invalid, so a new match needs PAT_LEN fresh bits.
            fill <= (match && !OVERLAP) ? '0 : fill_inc;
            hit  <= {m_b, m_a};
            Z    <= match;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counter; a simultaneous A and B match is one event.
    // ------------------------------------------------------------------
    always_ff @(posedge MHz) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr_cnt) begin
            count <= '0;
        end else if (step && match && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign full = (fill == FILL_MAX);
    assign led  = 1'b1;

endmodule

// File: tb/tb_seq_detect_gen.sv
module tb_seq_detect_gen;

    logic       MHz = 1'b0;
    logic       Reset = 1'b0;
    logic       PS3 = 1'b0;
    logic       W = 1'b0;
    logic [1:0] pat_en = 2'b11;
    logic       clr_cnt = 1'b0;

    logic [2:0] z_v, full_v, led_v;
    logic [1:0] hit0, hit1, hit2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    always #5 MHz = ~MHz;

    // instance 0: defaults, overlapping
    seq_detect_gen #(.DIV(4), .DB_LEN(3)) u_ov1 (
        .MHz(MHz), .Reset(Reset), .PS3(PS3), .W(W), .pat_en(pat_en), .clr_cnt(clr_cnt),
        .Z(z_v[0]), .hit(hit0), .count(cnt0), .full(full_v[0]), .led(led_v[0]));

    // instance 1: non-overlapping
    seq_detect_gen #(.DIV(4), .DB_LEN(3), .OVERLAP(1'b0)) u_ov0 (
        .MHz(MHz), .Reset(Reset), .PS3(PS3), .W(W), .pat_en(pat_en), .clr_cnt(clr_cnt),
        .Z(z_v[1]), .hit(hit1), .count(cnt1), .full(full_v[1]), .led(led_v[1]));

    // instance 2: small saturating counter, both patterns 1111
    seq_detect_gen #(.DIV(4), .DB_LEN(3), .CNT_W(2), .PAT_A(4'b1111), .PAT_B(4'b1111)) u_sat (
        .MHz(MHz), .Reset(Reset), .PS3(PS3), .W(W), .pat_en(pat_en), .clr_cnt(clr_cnt),
        .Z(z_v[2]), .hit(hit2), .count(cnt2), .full(full_v[2]), .led(led_v[2]));

    // ---------------- reference model: queue of valid bits ----------------
    int pa[3]   = '{9, 9, 15};
    int pb[3]   = '{15, 15, 15};
    int ovl[3]  = '{1, 0, 1};
    int cmax[3] = '{255, 255, 3};
    bit q0[$];
    bit q1[$];
    bit q2[$];
    int  mcnt[3];
    bit  mz[3];
    bit [1:0] mhit[3];
    bit  mfull[3];

    function automatic bit tail_eq(input bit q[$], input int pat);
        if (q.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (q[i] != bit'((pat >> (3 - i)) & 1)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; mz[k] = 0; mhit[k] = 2'b00; mfull[k] = 0;
        end
    endtask

    task automatic model_step(input bit w, input logic [1:0] en);
        for (int k = 0; k < 3; k++) begin
            bit q[$];
            bit ma, mb;
            case (k)
                0: q = q0;
                1: q = q1;
                default: q = q2;
            endcase
            q.push_back(w);
            if (q.size() > 4) void'(q.pop_front());
            ma = en[0] && tail_eq(q, pa[k]);
            mb = en[1] && tail_eq(q, pb[k]);
            mhit[k] = {mb, ma};
            mz[k] = ma | mb;
            if ((ma | mb) && mcnt[k] < cmax[k]) mcnt[k]++;
            if ((ma | mb) && ovl[k] == 0) q.delete();
            mfull[k] = (q.size() == 4);
            case (k)
                0: q0 = q;
                1: q1 = q;
                default: q2 = q;
            endcase
        end
    endtask

    // ---------------- observation helpers ----------------
    function automatic int get_cnt(input int k);
        case (k)
            0: return int'(cnt0);
            1: return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int get_hit(input int k);
        case (k)
            0: return int'(hit0);
            1: return int'(hit1);
            default: return int'(hit2);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input int k, input string tag);
        check($sformatf("%s[%0d].Z", tag, k), int'(z_v[k]), int'(mz[k]));
        check($sformatf("%s[%0d].hit", tag, k), get_hit(k), int'(mhit[k]));
        check($sformatf("%s[%0d].count", tag, k), get_cnt(k), mcnt[k]);
        check($sformatf("%s[%0d].full", tag, k), int'(full_v[k]), int'(mfull[k]));
    endtask

    // ---------------- stimulus tasks ----------------
    // clr_mode: 0 none, 1 pulse after the step, 2 held through the step
    task automatic do_step(input bit w, input logic [1:0] en, input int clr_mode, input bit scramble);
        W = w;
        pat_en = en;
        if (clr_mode == 2) clr_cnt = 1'b1;
        PS3 = 1'b1;
        repeat (24) @(negedge MHz);
        PS3 = 1'b0;
        model_step(w, en);
        if (scramble) pat_en = 2'($urandom_range(0, 3));
        repeat (4) @(negedge MHz);
        if (clr_mode == 1) begin
            clr_cnt = 1'b1;
            repeat (3) @(negedge MHz);
        end
        clr_cnt = 1'b0;
        if (clr_mode != 0)
            for (int k = 0; k < 3; k++) mcnt[k] = 0;
        repeat (20) @(negedge MHz);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        PS3 = 1'b0;
        clr_cnt = 1'b0;
        pat_en = 2'b11;
        repeat (3) @(negedge MHz);
        model_reset();
        Reset = 1'b1;
        @(negedge MHz);
    endtask

    typedef struct {
        bit       w;
        bit       exp_z;
        bit [1:0] exp_hit;
        int       exp_cnt;
        bit       exp_full;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 2'b00, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 2'b00, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 2'b00, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'b01, 1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 2'b00, 1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 2'b00, 1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 2'b10, 2, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 2'b10, 3, 1'b1};

        // 1: reset values
        Reset = 1'b0;
        repeat (3) @(negedge MHz);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset[%0d].Z", k), int'(z_v[k]), 0);
            check($sformatf("reset[%0d].hit", k), get_hit(k), 0);
            check($sformatf("reset[%0d].count", k), get_cnt(k), 0);
            check($sformatf("reset[%0d].full", k), int'(full_v[k]), 0);
            check($sformatf("reset[%0d].led", k), int'(led_v[k]), 1);
        end
        model_reset();
        Reset = 1'b1;
        @(negedge MHz);

        // 2: table-driven overlap sequence on instance 0
        for (int i = 0; i < 8; i++) begin
            do_step(vecs[i].w, 2'b11, 0, 1'b0);
            check($sformatf("tbl%0d.Z", i), int'(z_v[0]), int'(vecs[i].exp_z));
            check($sformatf("tbl%0d.hit", i), get_hit(0), int'(vecs[i].exp_hit));
            check($sformatf("tbl%0d.count", i), get_cnt(0), vecs[i].exp_cnt);
            check($sformatf("tbl%0d.full", i), int'(full_v[0]), int'(vecs[i].exp_full));
        end
        check("led_run", int'(led_v[0]), 1);

        // 3: overlap vs non-overlap on 1001001
        do_reset();
        do_step(1, 2'b11, 0, 0);
        do_step(0, 2'b11, 0, 0);
        do_step(0, 2'b11, 0, 0);
        do_step(1, 2'b11, 0, 0);
        check("novl.s4.Z", int'(z_v[1]), 1);
        check("novl.s4.count", get_cnt(1), 1);
        check("novl.s4.full", int'(full_v[1]), 0);
        do_step(0, 2'b11, 0, 0);
        do_step(0, 2'b11, 0, 0);
        do_step(1, 2'b11, 0, 0);
        check("novl.s7.Z", int'(z_v[1]), 0);
        check("novl.s7.count", get_cnt(1), 1);
        check("novl.s7.full", int'(full_v[1]), 0);
        check("ovl.s7.Z", int'(z_v[0]), 1);
        check("ovl.s7.count", get_cnt(0), 2);

        // 4: bouncing button gives one step; a short pulse gives none
        do_reset();
        do_step(1, 2'b11, 0, 0);
        do_step(1, 2'b11, 0, 0);
        do_step(1, 2'b11, 0, 0);
        check("bounce.pre.full", int'(full_v[0]), 0);
        W = 1'b1;
        for (int i = 0; i < 10; i++) begin
            PS3 = (i % 2 == 0);
            repeat (4) @(negedge MHz);
        end
        PS3 = 1'b1;
        repeat (24) @(negedge MHz);
        PS3 = 1'b0;
        repeat (24) @(negedge MHz);
        model_step(1'b1, 2'b11);
        check("bounce.count", get_cnt(0), 1);
        check("bounce.full", int'(full_v[0]), 1);
        check("bounce.hit", get_hit(0), 2);
        PS3 = 1'b1;
        repeat (8) @(negedge MHz);
        PS3 = 1'b0;
        repeat (24) @(negedge MHz);
        check("pulse.count", get_cnt(0), 1);

        // 5: saturation on the 2-bit counter, then clear during a match step
        do_reset();
        for (int s = 1; s <= 9; s++) begin
            do_step(1, 2'b11, 0, 0);
            check($sformatf("sat.s%0d.hit", s), get_hit(2), (s >= 4) ? 3 : 0);
            check($sformatf("sat.s%0d.count", s), get_cnt(2), (s >= 6) ? 3 : ((s >= 4) ? s - 3 : 0));
        end
        do_step(1, 2'b11, 2, 0);
        check("sat.clr.count", get_cnt(2), 0);
        check("sat.clr.hit", get_hit(2), 3);

        // 6: reset mid-sequence discards history
        do_reset();
        do_step(1, 2'b11, 0, 0);
        do_step(0, 2'b11, 0, 0);
        do_step(0, 2'b11, 0, 0);
        Reset = 1'b0;
        @(negedge MHz);
        Reset = 1'b1;
        model_reset();
        @(negedge MHz);
        do_step(1, 2'b11, 0, 0);
        check("rstmid.Z", int'(z_v[0]), 0);
        check("rstmid.full", int'(full_v[0]), 0);
        check("rstmid.count", get_cnt(0), 0);

        // random steps against the reference model
        do_reset();
        for (int n = 0; n < 150; n++) begin
            bit w;
            logic [1:0] en;
            int cm;
            w  = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            cm = ($urandom_range(0, 15) == 0) ? 1 : 0;
            do_step(w, en, cm, 1'b1);
            for (int k = 0; k < 3; k++) check_model(k, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
